// File: rtl/rr_stream_mux.sv
// N-channel valid/ready stream multiplexer with a single registered output stage.
// Arbitration is round-robin (RR=1) or fixed priority with channel 0 highest (RR=0).
module rr_stream_mux #(
  parameter int unsigned N_CH  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned RR    = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_CH-1:0]         in_valid,
  input  logic [N_CH*WIDTH-1:0]   in_data,
  output logic [N_CH-1:0]         in_ready,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] out_ch,
  input  logic                    out_ready
);

  localparam int unsigned CHW = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [CHW-1:0]   out_ch_q,    out_ch_d;
  logic [CHW-1:0]   ptr_q,       ptr_d;

  logic [WIDTH-1:0] ch_data [N_CH];
  logic [N_CH-1:0]  grant;
  logic [CHW-1:0]   gidx;
  logic             found;
  logic             load_en;
  logic             xfer;
  int unsigned      start;
  int unsigned      idx;

  // Unpack the flat data bus into per-channel words.
  always_comb begin
    for (int unsigned i = 0; i < N_CH; i++) begin
      ch_data[i] = in_data[i*WIDTH +: WIDTH];
    end
  end

  // First valid channel at or after the search start, wrapping at N_CH-1.
  always_comb begin
    found = 1'b0;
    gidx  = '0;
    idx   = 0;
    start = (RR != 0) ? 32'(ptr_q) : 32'd0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      idx = start + k;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!found && in_valid[CHW'(idx)]) begin
        found = 1'b1;
        gidx  = CHW'(idx);
      end
    end
    grant = found ? (N_CH'(1) << gidx) : '0;
  end

  assign load_en  = !out_valid_q || out_ready;
  assign xfer     = load_en && found;
  assign in_ready = load_en ? grant : '0;

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = ch_data[gidx];
      out_ch_d    = gidx;
      if (RR != 0) begin
        ptr_d = (gidx == CHW'(N_CH - 1)) ? '0 : gidx + CHW'(1);
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Bench for rr_stream_mux: a round-robin and a fixed-priority instance checked every
// cycle against a queue-free behavioural model, plus hand-computed literal expectations.
module tb_rr_stream_mux;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N-1:0]   iv   [2];
  logic [N*W-1:0] id   [2];
  logic           ordy [2];
  logic [N-1:0]   irdy [2];
  logic           ov   [2];
  logic [W-1:0]   od   [2];
  logic [1:0]     och  [2];

  rr_stream_mux #(.N_CH(4), .WIDTH(8), .RR(1)) u_rr (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_ready(irdy[0]),
    .out_valid(ov[0]), .out_data(od[0]), .out_ch(och[0]), .out_ready(ordy[0]));

  rr_stream_mux #(.N_CH(4), .WIDTH(8), .RR(0)) u_fp (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_ready(irdy[1]),
    .out_valid(ov[1]), .out_data(od[1]), .out_ch(och[1]), .out_ready(ordy[1]));

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model state per instance: output register contents and arbitration pointer.
  bit         m_v   [2];
  logic [W-1:0] m_d [2];
  int         m_ch  [2];
  int         m_ptr [2];
  int         m_g   [2];
  bit         m_pop [2];

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      int c;
      c = (start + k) % N;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  // Compare process: inputs are stable here, so grant is predicted and outputs checked.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        bit load;
        int g;
        logic [N-1:0] er;
        load = !m_v[i] || ordy[i];
        g = load ? pick(iv[i], (i == 0) ? m_ptr[i] : 0) : -1;
        m_g[i] = g;
        m_pop[i] = m_v[i] && ordy[i];
        er = (g >= 0) ? N'(1 << g) : '0;
        chk(i == 0 ? "rr_in_ready" : "fp_in_ready", 32'(irdy[i]), 32'(er));
        chk(i == 0 ? "rr_out_valid" : "fp_out_valid", 32'(ov[i]), 32'(m_v[i]));
        if (m_v[i]) begin
          chk(i == 0 ? "rr_out_data" : "fp_out_data", 32'(od[i]), 32'(m_d[i]));
          chk(i == 0 ? "rr_out_ch" : "fp_out_ch", 32'(och[i]), 32'(m_ch[i]));
        end
      end
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_v[i] = 1'b0; m_d[i] = '0; m_ch[i] = 0; m_ptr[i] = 0; m_g[i] = -1; m_pop[i] = 1'b0;
      end else if (m_g[i] >= 0) begin
        m_v[i]  = 1'b1;
        m_d[i]  = id[i][m_g[i]*W +: W];
        m_ch[i] = m_g[i];
        if (i == 0) m_ptr[i] = (m_g[i] + 1) % N;
      end else if (m_pop[i]) begin
        m_v[i] = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      m_v[i] = 1'b0; m_d[i] = '0; m_ch[i] = 0; m_ptr[i] = 0; m_g[i] = -1; m_pop[i] = 1'b0;
    end
    iv[0] = 4'b1111; id[0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; ordy[0] = 1'b1;
    iv[1] = 4'b0000; id[1] = {8'hD3, 8'hD2, 8'hD1, 8'hD0}; ordy[1] = 1'b1;
    tick(); tick();
    rst = 1'b0;

    // Reset state and round-robin stream A0,A1,A2,A3,A0,...
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (k == 0) begin
        chk("rst_in_ready", 32'(irdy[0]), 32'h1);
        chk("rst_out_valid", 32'(ov[0]), 32'h0);
        chk("rst_out_data", 32'(od[0]), 32'h0);
        chk("rst_out_ch", 32'(och[0]), 32'h0);
      end else begin
        chk("stream_ch", 32'(och[0]), 32'((k - 1) % 4));
        chk("stream_data", 32'(od[0]), 32'(8'hA0 + (k - 1) % 4));
        chk("stream_valid", 32'(ov[0]), 32'h1);
      end
    end

    // Only ch2 valid for three words, then ch1 after the pointer wraps.
    tick(); iv[0] = 4'b0100; id[0][2*W +: W] = 8'hC0;
    tick(); id[0][2*W +: W] = 8'hC1;
    tick(); id[0][2*W +: W] = 8'hC2;
    tick(); iv[0] = 4'b0010; id[0][1*W +: W] = 8'hB1;
    @(negedge clk);
    chk("ch2_last_data", 32'(od[0]), 32'hC2);
    chk("ch2_last_ch", 32'(och[0]), 32'h2);
    chk("ch1_wrap_grant", 32'(irdy[0]), 32'h2);
    tick(); iv[0] = 4'b0000;
    @(negedge clk);
    chk("ch1_data", 32'(od[0]), 32'hB1);
    chk("ch1_ch", 32'(och[0]), 32'h1);

    // Stall for five cycles while holding ch3 word E3.
    tick(); iv[0] = 4'b1000; id[0][3*W +: W] = 8'hE3;
    tick(); ordy[0] = 1'b0; iv[0] = 4'b1001; id[0][0 +: W] = 8'hE0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 32'(ov[0]), 32'h1);
      chk("stall_data", 32'(od[0]), 32'hE3);
      chk("stall_in_ready", 32'(irdy[0]), 32'h0);
      tick();
    end
    ordy[0] = 1'b1;
    @(negedge clk);
    chk("release_grant", 32'(irdy[0]), 32'h1);
    tick(); iv[0] = 4'b0000;
    @(negedge clk);
    chk("release_data", 32'(od[0]), 32'hE0);
    chk("release_ch", 32'(och[0]), 32'h0);

    // Fixed priority: ch0 starves ch3 until ch0 drops.
    tick(); iv[1] = 4'b1001;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("fp_grant_ch0", 32'(irdy[1]), 32'h1);
      if (k > 0) chk("fp_out_ch0", 32'(och[1]), 32'h0);
      tick();
    end
    iv[1] = 4'b1000;
    @(negedge clk);
    chk("fp_grant_ch3", 32'(irdy[1]), 32'h8);
    tick(); iv[1] = 4'b0000;
    @(negedge clk);
    chk("fp_out_ch3", 32'(och[1]), 32'h3);
    chk("fp_out_d3", 32'(od[1]), 32'hD3);

    // Reset while stalled with a held word; that word must be discarded.
    tick(); iv[0] = 4'b0010; id[0][1*W +: W] = 8'hF1; ordy[0] = 1'b0;
    tick(); iv[0] = 4'b0000;
    @(negedge clk);
    chk("pre_rst_valid", 32'(ov[0]), 32'h1);
    chk("pre_rst_data", 32'(od[0]), 32'hF1);
    tick(); rst = 1'b1;
    tick(); rst = 1'b0; ordy[0] = 1'b1; iv[0] = 4'b1111; id[0] = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    @(negedge clk);
    chk("post_rst_valid", 32'(ov[0]), 32'h0);
    chk("post_rst_ptr_grant", 32'(irdy[0]), 32'h1);
    tick();
    @(negedge clk);
    chk("post_rst_data", 32'(od[0]), 32'hA0);
    chk("post_rst_ch", 32'(och[0]), 32'h0);
    tick(); iv[0] = 4'b0000;
    tick(); tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
